gpio_bank_ctrl: RTL and testbench
=================================

GPIO_BANK_CTRL -- requirements
Module: gpio_bank_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops per pin (legal 2..4).
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of 4-bit pin banks (fixed at 4 in this release).
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  1  register access request.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  5  {bank[4:3], reg[2:0]}.
REQ-008 wdata_i  input  4  write data.
REQ-009 ack_o  output  1  one-cycle access completion pulse.
REQ-010 rdata_o  output  4  read data, valid only while ack_o=1, else 0.
REQ-011 irq_o  output  1  registered OR of all banks' (STAT & MASK).
REQ-012 b3_data_io, b2_data_io, b1_data_io, b0_data_io  inout  4 each  pin banks 3..0.

Function
REQ-013 Per-bank registers, reg code: 0 DIR (1 = drive), 1 OUT, 2 IN (read-only), 3 EDGE (0 = rising, 1 = falling), 4 STAT (write-1-to-clear), 5 MASK; codes 6-7 unmapped.
REQ-014 Each pin bit SHALL drive OUT[bit] when DIR[bit]=1 and be high-impedance when DIR[bit]=0.
REQ-015 Each pin SHALL pass through a SYNC_STAGES-deep flop chain; IN = last stage, independent of DIR (loopback readable).
REQ-016 Access accepted on a rising edge where req_i=1 and ack_o=0; ack_o=1 on the following cycle; requests while ack_o=1 ignored.
REQ-017 Write to DIR/OUT/EDGE/MASK takes effect in the accept cycle's edge (pin drives new value one cycle after accept).
REQ-018 Write to IN or unmapped codes: no state change, ack_o still pulses.
REQ-019 Read returns register value captured at accept; unmapped codes return 4'h0.
REQ-020 Edge detector per bit: compares IN with its previous-cycle value; event = rising (0->1) if EDGE=0, falling (1->0) if EDGE=1.
REQ-021 Event SHALL set STAT[bit] only when DIR[bit]=0 and detector armed.
REQ-022 STAT bit cleared by writing 1; writing 0 leaves it unchanged.
REQ-023 Same-cycle event and clear on same bit: set wins (STAT stays 1).
REQ-024 Latency, SYNC_STAGES=2: pin change before edge N -> IN updates at N+1, STAT sets at N+2, irq_o high at N+3.
REQ-025 irq_o SHALL deassert one cycle after last enabled STAT bit clears or its MASK bit clears.
REQ-026 Changing EDGE or DIR SHALL not by itself create an event; only IN transitions do.

Reset
REQ-027 While rst_i=1: DIR, OUT, EDGE, STAT, MASK, sync chains, previous-IN = 0; ack_o=0, rdata_o=0, irq_o=0; all pins high-impedance.
REQ-028 Detector SHALL be disarmed for SYNC_STAGES+1 cycles after rst_i deasserts, preventing false edges from pins already high.
REQ-029 Reset asserted mid-access SHALL abort it: no ack_o, no register update.

Verification
REQ-030 Reset with b0 pins externally 4'hF -> after release, STAT bank0 stays 0, irq_o stays 0, IN bank0 reads 4'hF.
REQ-031 Write DIR bank2=4'hF, OUT bank2=4'hA -> b2_data_io=4'hA one cycle after OUT ack; read IN bank2 = 4'hA after SYNC_STAGES cycles.
REQ-032 MASK bank1=4'h1, EDGE=0, b1 bit0 driven 0->1 before edge N -> STAT bank1=4'h1 at N+2, irq_o=1 at N+3; write STAT 4'h1 -> irq_o=0 one cycle after clear.
REQ-033 Falling mode: EDGE bank3=4'h8, bit3 1->0 -> STAT bank3=4'h8; rising on bit3 -> no set.
REQ-034 Clear STAT bit0 same cycle as new rising event on bit0 -> STAT bit0 remains 1, irq_o remains 1.
REQ-035 Read addr code 7, write to IN -> ack_o pulses once each, rdata_o=4'h0, no register changes; back-to-back req_i held high -> ack every second cycle.

Source files
------------

// File: rtl/gpio_bank_ctrl_if.sv
// Register-access bus for gpio_bank_ctrl.
//
// Handshake: the master raises req_i together with we_i/addr_i/wdata_i.
// A request is accepted on a rising edge where req_i=1 and ack_o=0. The
// slave answers with a single-cycle ack_o pulse on the next cycle; rdata_o
// carries the read value only while ack_o=1 and is 0 otherwise. Any request
// presented while ack_o=1 is ignored, so a master that holds req_i high sees
// one ack every second cycle. irq_o is a level and not part of the handshake.
// acc_state mirrors the slave's access FSM for observation.
interface gpio_bank_ctrl_if;
  logic       req_i;
  logic       we_i;
  logic [4:0] addr_i;
  logic [3:0] wdata_i;
  logic       ack_o;
  logic [3:0] rdata_o;
  logic       irq_o;
  logic       acc_state;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, irq_o, acc_state
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, irq_o, acc_state
  );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// Four banks of four bidirectional GPIO pins. Each bank has DIR/OUT/IN/EDGE/
// STAT/MASK registers; inputs are synchronised, edge-detected into sticky
// STAT bits, and the masked STAT bits are ORed into a registered interrupt.
module gpio_bank_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BANKS   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gpio_bank_ctrl_if.slave  bus,
  inout  wire  [3:0]       b3_data_io,
  inout  wire  [3:0]       b2_data_io,
  inout  wire  [3:0]       b1_data_io,
  inout  wire  [3:0]       b0_data_io
);

  localparam logic [2:0] REG_DIR  = 3'd0;
  localparam logic [2:0] REG_OUT  = 3'd1;
  localparam logic [2:0] REG_IN   = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;
  localparam logic [2:0] REG_MASK = 3'd5;

  // Detector stays blind until the synchronisers and previous-IN register
  // have been refilled from the real pin levels after reset.
  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} acc_state_t;

  acc_state_t state_q;
  logic       ack_q;
  logic [3:0] rdata_q;
  logic       irq_q;
  logic       irq_next;

  logic [3:0] dir_q  [NUM_BANKS];
  logic [3:0] out_q  [NUM_BANKS];
  logic [3:0] edge_q [NUM_BANKS];
  logic [3:0] stat_q [NUM_BANKS];
  logic [3:0] mask_q [NUM_BANKS];
  logic [3:0] prev_q [NUM_BANKS];
  logic [3:0] sync_q [NUM_BANKS][SYNC_STAGES];

  logic [3:0] pin_in   [NUM_BANKS];
  logic [3:0] in_val   [NUM_BANKS];
  logic [3:0] evt      [NUM_BANKS];
  logic [3:0] stat_clr [NUM_BANKS];

  logic [2:0] arm_cnt_q;
  logic       armed;
  logic       accept;
  logic [1:0] acc_bank;
  logic [2:0] acc_reg;
  logic [3:0] rd_val;

  assign acc_bank = bus.addr_i[4:3];
  assign acc_reg  = bus.addr_i[2:0];
  assign accept   = bus.req_i && (state_q == ST_IDLE);
  assign armed    = (arm_cnt_q == ARM_CYCLES);

  assign pin_in[0] = b0_data_io;
  assign pin_in[1] = b1_data_io;
  assign pin_in[2] = b2_data_io;
  assign pin_in[3] = b3_data_io;

  // Per-bit tristate drivers: drive OUT where DIR=1, float otherwise.
  for (genvar k = 0; k < 4; k++) begin : g_pad
    assign b0_data_io[k] = dir_q[0][k] ? out_q[0][k] : 1'bz;
    assign b1_data_io[k] = dir_q[1][k] ? out_q[1][k] : 1'bz;
    assign b2_data_io[k] = dir_q[2][k] ? out_q[2][k] : 1'bz;
    assign b3_data_io[k] = dir_q[3][k] ? out_q[3][k] : 1'bz;
  end

  // Per-bank edge events and write-1-to-clear masks.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign in_val[b] = sync_q[b][SYNC_STAGES-1];
    assign evt[b] = ((edge_q[b] & prev_q[b] & ~in_val[b]) |
                     (~edge_q[b] & ~prev_q[b] & in_val[b])) &
                    ~dir_q[b] & {4{armed}};
    assign stat_clr[b] = (accept && bus.we_i && (acc_bank == 2'(b)) &&
                          (acc_reg == REG_STAT)) ? bus.wdata_i : 4'h0;
  end

  // Read mux: value of the addressed register as it stands before the accept edge.
  always_comb begin
    rd_val = 4'h0;
    case (acc_reg)
      REG_DIR:  rd_val = dir_q[acc_bank];
      REG_OUT:  rd_val = out_q[acc_bank];
      REG_IN:   rd_val = in_val[acc_bank];
      REG_EDGE: rd_val = edge_q[acc_bank];
      REG_STAT: rd_val = stat_q[acc_bank];
      REG_MASK: rd_val = mask_q[acc_bank];
      default:  rd_val = 4'h0;
    endcase
  end

  // Interrupt source: any enabled sticky bit in any bank.
  always_comb begin
    irq_next = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      irq_next = irq_next | (|(stat_q[b] & mask_q[b]));
    end
  end

  // Access FSM: accept, perform the write, and pulse ack with read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 4'h0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        dir_q[b]  <= 4'h0;
        out_q[b]  <= 4'h0;
        edge_q[b] <= 4'h0;
        mask_q[b] <= 4'h0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_i) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            rdata_q <= bus.we_i ? 4'h0 : rd_val;
            if (bus.we_i) begin
              case (acc_reg)
                REG_DIR:  dir_q[acc_bank]  <= bus.wdata_i;
                REG_OUT:  out_q[acc_bank]  <= bus.wdata_i;
                REG_EDGE: edge_q[acc_bank] <= bus.wdata_i;
                REG_MASK: mask_q[acc_bank] <= bus.wdata_i;
                default:  ;
              endcase
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= 4'h0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= 4'h0;
        end
      endcase
    end
  end

  // Input path: synchronisers, previous-IN, arming counter, sticky STAT, irq.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_cnt_q <= 3'd0;
      irq_q     <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        stat_q[b] <= 4'h0;
        prev_q[b] <= 4'h0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[b][s] <= 4'h0;
        end
      end
    end else begin
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + 3'd1;
      end
      irq_q <= irq_next;
      for (int b = 0; b < NUM_BANKS; b++) begin
        sync_q[b][0] <= pin_in[b];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[b][s] <= sync_q[b][s-1];
        end
        prev_q[b] <= in_val[b];
        // A new event outranks a same-cycle clear.
        stat_q[b] <= (stat_q[b] & ~stat_clr[b]) | evt[b];
      end
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.irq_o     = irq_q;
  assign bus.acc_state = state_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Bench for gpio_bank_ctrl: register accesses push expected read data to a
// queue, a negedge monitor pops and compares on every ack; pin, latency and
// interrupt behaviour are checked directly against bench-side constants.
module tb_gpio_bank_ctrl;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic rst;
  gpio_bank_ctrl_if bus();

  wire [3:0] b0_pins, b1_pins, b2_pins, b3_pins;
  logic [3:0] tb_en  [4];
  logic [3:0] tb_val [4];

  logic [4:0] exp_q[$];   // {is_read, expected rdata}
  logic [4:0] mon_ent;
  int n_checks;
  int n_errors;

  gpio_bank_ctrl #(.SYNC_STAGES(SYNC_STAGES), .NUM_BANKS(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .b3_data_io (b3_pins),
    .b2_data_io (b2_pins),
    .b1_data_io (b1_pins),
    .b0_data_io (b0_pins)
  );

  // External pin drivers, one enable per bit.
  for (genvar k = 0; k < 4; k++) begin : g_drv
    assign b0_pins[k] = tb_en[0][k] ? tb_val[0][k] : 1'bz;
    assign b1_pins[k] = tb_en[1][k] ? tb_val[1][k] : 1'bz;
    assign b2_pins[k] = tb_en[2][k] ? tb_val[2][k] : 1'bz;
    assign b3_pins[k] = tb_en[3][k] ? tb_val[3][k] : 1'bz;
  end

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] ra(input int bank, input int r);
    return {2'(bank), 3'(r)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One access: request is accepted on the next edge, ack is seen after it,
  // and the task returns one cycle later with ack low again.
  task automatic acc(input logic we, input logic [4:0] addr, input logic [3:0] wd,
                     input logic [3:0] exp);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wd;
    exp_q.push_back({~we, exp});
    tick(1);
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.wdata_i = 4'h0;
    tick(1);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [3:0] wd);
    acc(1'b1, addr, wd, 4'h0);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [3:0] exp);
    acc(1'b0, addr, 4'h0, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack_o) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_ack", 32'(bus.ack_o), 32'd0);
        end else begin
          mon_ent = exp_q.pop_front();
          if (mon_ent[4]) check_val("sb_rdata", 32'(bus.rdata_o), 32'(mon_ent[3:0]));
        end
      end else begin
        check_val("rdata_idle", 32'(bus.rdata_o), 32'd0);
      end
    end
  end

  initial begin
    int rb;
    int rr;
    logic [3:0] rv;
    n_checks = 0;
    n_errors = 0;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = 5'd0;
    bus.wdata_i = 4'h0;
    for (int b = 0; b < 4; b++) begin
      tb_en[b]  = 4'hF;
      tb_val[b] = 4'h0;
    end
    tb_val[0] = 4'hF;
    rst = 1'b1;
    tick(3);
    check_val("rst_ack", 32'(bus.ack_o), 32'd0);
    check_val("rst_rdata", 32'(bus.rdata_o), 32'd0);
    check_val("rst_irq", 32'(bus.irq_o), 32'd0);
    check_val("rst_state", 32'(bus.acc_state), 32'd0);

    // Pins already high at reset release must not raise STAT.
    rst = 1'b0;
    tick(8);
    check_val("post_rst_irq", 32'(bus.irq_o), 32'd0);
    rd(ra(0, 4), 4'h0);
    rd(ra(0, 2), 4'hF);
    tb_val[0] = 4'h0;
    tick(4);

    // Output drive and loopback on bank 2.
    tb_en[2] = 4'h0;
    wr(ra(2, 0), 4'hF);
    wr(ra(2, 1), 4'hA);
    check_val("b2_pins", 32'(b2_pins), 32'hA);
    tick(SYNC_STAGES);
    rd(ra(2, 2), 4'hA);
    rd(ra(2, 0), 4'hF);
    rd(ra(2, 1), 4'hA);

    // Random EDGE/OUT readback; EDGE changes alone must not create events.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rb = $urandom_range(0, 3);
        rr = 3;
      end else begin
        rb = 2 * $urandom_range(0, 1) + 1;
        rr = 1;
      end
      rv = 4'($urandom_range(0, 15));
      wr(ra(rb, rr), rv);
      rd(ra(rb, rr), rv);
    end
    for (int b = 0; b < 4; b++) wr(ra(b, 3), 4'h0);
    rd(ra(0, 4), 4'h0);
    rd(ra(1, 4), 4'h0);
    rd(ra(3, 4), 4'h0);

    // Pins driven by the block itself never set STAT.
    wr(ra(2, 1), 4'h5);
    tick(4);
    rd(ra(2, 2), 4'h5);
    rd(ra(2, 4), 4'h0);

    // Rising edge latency on bank 1 bit 0.
    wr(ra(1, 5), 4'h1);
    tb_val[1][0] = 1'b1;
    tick(1);
    check_val("lat_irq_n", 32'(bus.irq_o), 32'd0);
    tick(2);
    check_val("lat_irq_n2", 32'(bus.irq_o), 32'd0);
    tick(1);
    check_val("lat_irq_n3", 32'(bus.irq_o), 32'd1);
    rd(ra(1, 4), 4'h1);
    wr(ra(1, 4), 4'h1);
    check_val("irq_after_clr", 32'(bus.irq_o), 32'd0);
    rd(ra(1, 4), 4'h0);

    // Write-0 leaves STAT alone.
    tb_val[1][0] = 1'b0;
    tick(4);
    rd(ra(1, 4), 4'h0);
    tb_val[1][0] = 1'b1;
    tick(5);
    rd(ra(1, 4), 4'h1);
    check_val("irq_rise2", 32'(bus.irq_o), 32'd1);
    wr(ra(1, 4), 4'h0);
    rd(ra(1, 4), 4'h1);
    wr(ra(1, 4), 4'h1);
    rd(ra(1, 4), 4'h0);

    // Clear accepted on the very edge where a new event sets the bit.
    tb_val[1][0] = 1'b0;
    tick(4);
    tb_val[1][0] = 1'b1;
    tick(2);
    wr(ra(1, 4), 4'h1);
    check_val("setwins_irq", 32'(bus.irq_o), 32'd1);
    rd(ra(1, 4), 4'h1);
    wr(ra(1, 4), 4'h1);
    check_val("setwins_clr_irq", 32'(bus.irq_o), 32'd0);

    // Falling mode on bank 3 bit 3.
    wr(ra(3, 3), 4'h8);
    tb_val[3][3] = 1'b1;
    tick(5);
    rd(ra(3, 4), 4'h0);
    tb_val[3][3] = 1'b0;
    tick(5);
    rd(ra(3, 4), 4'h8);
    wr(ra(3, 5), 4'h8);
    check_val("fall_irq", 32'(bus.irq_o), 32'd1);
    wr(ra(3, 5), 4'h0);
    check_val("mask_clr_irq", 32'(bus.irq_o), 32'd0);
    wr(ra(3, 4), 4'h8);
    rd(ra(3, 4), 4'h0);

    // Unmapped codes and IN writes.
    rd(ra(0, 7), 4'h0);
    rd(ra(2, 6), 4'h0);
    wr(ra(2, 2), 4'hF);
    rd(ra(2, 2), 4'h5);
    rd(ra(2, 1), 4'h5);
    wr(ra(1, 6), 4'hF);
    wr(ra(1, 7), 4'hF);
    rd(ra(1, 5), 4'h1);
    rd(ra(1, 0), 4'h0);
    rd(ra(1, 3), 4'h0);

    // Request held high: ack on every second cycle.
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 4'hF});
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = ra(2, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_val("b2b_ack", 32'(bus.ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.req_i = 1'b0;
    tick(1);

    // Reset arriving with a request aborts it.
    wr(ra(2, 0), 4'h0);
    tb_en[2]  = 4'hF;
    tb_val[2] = 4'h0;
    rst = 1'b1;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = ra(1, 5);
    bus.wdata_i = 4'hF;
    tick(1);
    check_val("abort_ack_rst", 32'(bus.ack_o), 32'd0);
    rst = 1'b0;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    tick(1);
    check_val("abort_ack_after", 32'(bus.ack_o), 32'd0);
    check_val("abort_irq", 32'(bus.irq_o), 32'd0);
    tick(5);
    rd(ra(1, 5), 4'h0);
    rd(ra(2, 0), 4'h0);

    tick(2);
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
